serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 21 ++
 rtl/addsub_bit_cell.sv | 26 ++
 rtl/serial_addsub.sv | 150 +++++++++++++++
 tb/tb_serial_addsub.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types, mode encodings and step-count helper for the serial add/subtract unit.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Returns 0 for an illegal chunking so the top can reject the configuration.
  function automatic int unsigned calc_steps(input int unsigned width, input int unsigned bpc);
    if (bpc == 0 || (width % bpc) != 0) begin
      return 0;
    end
    return width / bpc;
  endfunction

endpackage

// File: rtl/addsub_bit_cell.sv
// Combinational 1-bit full adder (mode=0) / full subtractor (mode=1).
module addsub_bit_cell
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  input  logic mode,
  output logic s,
  output logic c_out
);

  logic axb;

  assign axb = a ^ b;
  assign s   = axb ^ c_in;

  always_comb begin
    if (mode == MODE_SUB) begin
      c_out = (~a & b) | (c_in & ~axb);
    end else begin
      c_out = (a & b) | (c_in & axb);
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle LSB-first add/subtract, BITS_PER_CYCLE bits per clock.
// Define SERIAL_ADDSUB_OVF_EN to enable the registered signed-overflow flag.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (STEPS == 0 || WIDTH < 2) begin : g_cfg_err
    $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
  logic                mode_q, mode_d, carry_q, carry_d, cout_q, cout_d;
  logic                last_step;
  logic [BITS_PER_CYCLE-1:0] chunk_s;
  logic [BITS_PER_CYCLE:0]   chain;

  assign chain[0] = carry_q;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_cells
    addsub_bit_cell u_cell (
      .a     (a_sh_q[gi]),
      .b     (b_sh_q[gi]),
      .c_in  (chain[gi]),
      .mode  (mode_q),
      .s     (chunk_s[gi]),
      .c_out (chain[gi+1])
    );
  end

  assign last_step = (state_q == StRun) && (cnt_q == CntW'(STEPS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          mode_d  = mode;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d  = a_sh_q >> BITS_PER_CYCLE;
        b_sh_d  = b_sh_q >> BITS_PER_CYCLE;
        // New chunk enters at the MSB end so the word is aligned after STEPS shifts.
        res_d   = (res_q >> BITS_PER_CYCLE) | (WIDTH'(chunk_s) << (WIDTH - BITS_PER_CYCLE));
        carry_d = chain[BITS_PER_CYCLE];
        cout_d  = chain[BITS_PER_CYCLE];
        cnt_d   = cnt_q + 1'b1;
        if (last_step) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
  logic a_msb, b_msb, s_msb;

  // On the last step the low chunk bits of the shifters hold the original sign bits.
  assign a_msb = a_sh_q[BITS_PER_CYCLE-1];
  assign b_msb = b_sh_q[BITS_PER_CYCLE-1];
  assign s_msb = chunk_s[BITS_PER_CYCLE-1];

  always_comb begin
    ovf_d = ovf_q;
    if (last_step) begin
      if (mode_q == MODE_ADD) begin
        ovf_d = (a_msb == b_msb) && (s_msb != a_msb);
      end else begin
        ovf_d = (a_msb != b_msb) && (s_msb != a_msb);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ready  = (state_q == StIdle);
  assign done   = (state_q == StDone);
  assign result = res_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: arithmetic model + per-cycle compare for the 8-bit DUT, directed vectors.
module tb_serial_addsub;

  localparam int unsigned S8  = 8;
  localparam int unsigned S16 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, mode8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic        ready8, done8, cout8, ovf8;

  logic        start16 = 1'b0, mode16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic        ready16, done16, cout16, ovf16;

  int tests = 0;
  int fails = 0;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16), .cin(cin16),
    .ready(ready16), .done(done16), .result(res16), .cout(cout16), .ovf(ovf16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {ovf, cout, result} from plain integer arithmetic.
  function automatic logic [9:0] model8(input logic m, input logic [7:0] a, input logic [7:0] b,
                                        input logic c);
    logic [8:0] full;
    logic [7:0] r;
    logic       co, ov;
    if (!m) begin
      full = {1'b0, a} + {1'b0, b} + {8'b0, c};
      r    = full[7:0];
      co   = full[8];
      ov   = (a[7] == b[7]) && (r[7] != a[7]);
    end else begin
      r  = a - b - {7'b0, c};
      co = (32'(a) < 32'(b) + 32'(c));
      ov = (a[7] != b[7]) && (r[7] != a[7]);
    end
`ifndef SERIAL_ADDSUB_OVF_EN
    ov = 1'b0;
`endif
    return {ov, co, r};
  endfunction

  // Model: m_cnt = 0 idle, 1..S8 running, S8+1 done cycle.
  int          m_cnt = 0;
  logic [9:0]  m_q[$];
  logic [7:0]  m_res = '0;
  logic        m_cout = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_q.delete();
      m_res = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_cnt == 0) begin
      if (start8) begin
        m_q.push_back(model8(mode8, a8, b8, cin8));
        m_cnt = 1;
      end
    end else if (m_cnt == S8 + 1) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == S8 + 1 && m_q.size() > 0) {m_ovf, m_cout, m_res} = m_q.pop_front();
    end
  end

  always @(negedge clk) begin
    check("ready8", ready8, m_cnt == 0);
    check("done8", done8, m_cnt == S8 + 1);
    if (m_cnt == 0 || m_cnt == S8 + 1) begin
      check("result8", res8, m_res);
      check("cout8", cout8, m_cout);
      check("ovf8", ovf8, m_ovf);
    end
  end

  task automatic wait_ready8();
    int n = 0;
    @(negedge clk);
    while (!ready8 && n < 50) begin @(negedge clk); n++; end
    check("ready8_wait", ready8, 1);
  endtask

  task automatic op8(input string name, input logic m, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] er, input logic ec, input logic eo);
    int lat = 0;
    bit got = 0;
    logic exp_ovf;
`ifdef SERIAL_ADDSUB_OVF_EN
    exp_ovf = eo;
`else
    exp_ovf = 1'b0;
`endif
    wait_ready8();
    start8 = 1'b1; mode8 = m; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom); cin8 = 1'($urandom);
    while (!got && lat < 40) begin
      @(posedge clk); lat++; #1;
      if (done8) got = 1;
    end
    check({name, " latency"}, lat, S8);
    check({name, " result"}, res8, er);
    check({name, " cout"}, cout8, ec);
    check({name, " ovf"}, ovf8, exp_ovf);
  endtask

  initial begin
    int lat;
    int dcount;
    int rcount;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    check("reset ready", ready8, 1);
    check("reset result", res8, 0);

    op8("add_carry", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("sub_borrow", 1'b1, 8'h05, 8'h07, 1'b1, 8'hFD, 1'b1, 1'b0);
    op8("sub_plain", 1'b1, 8'h07, 8'h05, 1'b0, 8'h02, 1'b0, 1'b0);
    op8("sub_equal", 1'b1, 8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
    op8("sub_zero_bin", 1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8("add_all_ones", 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8("ovf_add", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("ovf_sub", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op8("no_ovf_sub", 1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Reset in the middle of a run.
    wait_ready8();
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst ready", ready8, 1);
    check("midrst done", done8, 0);
    check("midrst result", res8, 0);
    check("midrst cout", cout8, 0);
    check("midrst ovf", ovf8, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    op8("post_rst_add", 1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    // 16-bit, 4 bits per cycle.
    @(negedge clk);
    start16 = 1'b1; mode16 = 1'b0; a16 = 16'h1234; b16 = 16'h0FCC; cin16 = 1'b0;
    check("w16 ready", ready16, 1);
    @(posedge clk); #1 start16 = 1'b0; a16 = '1; b16 = '1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); lat++; #1;
      if (done16) break;
    end
    check("w16 latency", lat, S16);
    check("w16 result", res16, 16'h2200);
    check("w16 cout", cout16, 0);
    check("w16 ovf", ovf16, 0);

    // Back-to-back: start held high, operands churn every cycle.
    wait_ready8();
    start8 = 1'b1;
    dcount = 0; rcount = 0;
    for (int i = 0; i < 3 * (S8 + 2); i++) begin
      @(posedge clk); #1;
      if (done8) dcount++;
      if (ready8) rcount++;
      a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom); cin8 = 1'($urandom);
    end
    start8 = 1'b0;
    check("b2b dones", dcount, 3);
    check("b2b ready", rcount, 3);
    wait_ready8();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
